// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory bus between instruction fetch (I)
// and load/store (D); D has priority, bounded by a starvation limit for I.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        I_REQ,
  input  logic [31:0] I_ADDR,
  output logic        I_ACK,
  output logic [31:0] I_RDDATA,
  input  logic        D_RDEN,
  input  logic        D_WREN,
  input  logic [31:0] D_ADDR,
  input  logic [3:0]  D_STRB,
  input  logic [31:0] D_WRDATA,
  output logic        D_ACK,
  output logic [31:0] D_RDDATA,
  output logic        STALL,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  MEM_STRB,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDDATA,
  output logic [1:0]  DBG_STATE,
  output logic [7:0]  DBG_STREAK
);

  // Handshake: a requester raises I_REQ or D_RDEN/D_WREN with stable address
  // and data, and holds it until its one-cycle x_ACK; the bus side holds
  // MEM_REQ and every MEM_* field constant until MEM_ACK is sampled high.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t     state;
  logic [7:0] streak;
  logic [7:0] streak_inc;
  logic       d_req;
  logic       d_wins;

  assign d_req      = D_RDEN | D_WREN;
  assign d_wins     = d_req && (!I_REQ || (LIMIT == 8'd0) || (streak < LIMIT));
  assign streak_inc = (streak < LIMIT) ? streak + 8'd1 : streak;

  assign STALL      = d_req & ~D_ACK;
  assign DBG_STATE  = state;
  assign DBG_STREAK = streak;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      streak    <= '0;
      I_ACK     <= 1'b0;
      D_ACK     <= 1'b0;
      I_RDDATA  <= '0;
      D_RDDATA  <= '0;
      MEM_REQ   <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_STRB  <= '0;
      MEM_WDATA <= '0;
    end else begin
      I_ACK <= 1'b0;
      D_ACK <= 1'b0;
      case (state)
        IDLE: begin
          if (d_wins) begin
            state     <= GRANT_D;
            MEM_REQ   <= 1'b1;
            MEM_WE    <= D_WREN;
            MEM_ADDR  <= D_ADDR;
            MEM_STRB  <= D_WREN ? D_STRB : 4'hF;
            MEM_WDATA <= D_WREN ? D_WRDATA : '0;
            // Streak only counts grants that made a waiting fetch wait longer.
            streak    <= I_REQ ? streak_inc : '0;
          end else if (I_REQ) begin
            state     <= GRANT_I;
            MEM_REQ   <= 1'b1;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= I_ADDR;
            MEM_STRB  <= 4'hF;
            MEM_WDATA <= '0;
            streak    <= '0;
          end else begin
            streak <= '0;
          end
        end
        GRANT_I: begin
          if (MEM_ACK) begin
            state    <= DONE;
            MEM_REQ  <= 1'b0;
            I_ACK    <= 1'b1;
            I_RDDATA <= MEM_RDDATA;
          end
        end
        GRANT_D: begin
          if (MEM_ACK) begin
            state   <= DONE;
            MEM_REQ <= 1'b0;
            D_ACK   <= 1'b1;
            if (!MEM_WE) begin
              D_RDDATA <= MEM_RDDATA;
            end
          end
        end
        DONE: begin
          // Dead cycle so the acked requester can drop its request.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int LIM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        i_req, d_rden, d_wren, mem_ack;
  logic [31:0] i_addr, d_addr, d_wrdata, mem_rddata;
  logic [3:0]  d_strb;
  logic        i_ack, d_ack, stall, mem_req, mem_we;
  logic [31:0] i_rddata, d_rddata, mem_addr, mem_wdata;
  logic [3:0]  mem_strb;
  logic [1:0]  dbg_state;
  logic [7:0]  dbg_streak;

  logic        z_i_req, z_d_rden, z_mem_ack;
  logic [31:0] z_mem_rddata;
  logic        z_i_ack, z_d_ack, z_stall, z_mem_req, z_mem_we;
  logic [31:0] z_i_rddata, z_d_rddata, z_mem_addr, z_mem_wdata;
  logic [3:0]  z_mem_strb;
  logic [1:0]  z_dbg_state;
  logic [7:0]  z_dbg_streak;

  mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .CLK(clk), .RST(rst),
    .I_REQ(i_req), .I_ADDR(i_addr), .I_ACK(i_ack), .I_RDDATA(i_rddata),
    .D_RDEN(d_rden), .D_WREN(d_wren), .D_ADDR(d_addr), .D_STRB(d_strb),
    .D_WRDATA(d_wrdata), .D_ACK(d_ack), .D_RDDATA(d_rddata), .STALL(stall),
    .MEM_REQ(mem_req), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_STRB(mem_strb),
    .MEM_WDATA(mem_wdata), .MEM_ACK(mem_ack), .MEM_RDDATA(mem_rddata),
    .DBG_STATE(dbg_state), .DBG_STREAK(dbg_streak)
  );

  mem_port_arbiter #(.STARVE_LIMIT(0)) dut0 (
    .CLK(clk), .RST(rst),
    .I_REQ(z_i_req), .I_ADDR(32'h0000_3000), .I_ACK(z_i_ack), .I_RDDATA(z_i_rddata),
    .D_RDEN(z_d_rden), .D_WREN(1'b0), .D_ADDR(32'h0000_0400), .D_STRB(4'h0),
    .D_WRDATA(32'h0), .D_ACK(z_d_ack), .D_RDDATA(z_d_rddata), .STALL(z_stall),
    .MEM_REQ(z_mem_req), .MEM_WE(z_mem_we), .MEM_ADDR(z_mem_addr), .MEM_STRB(z_mem_strb),
    .MEM_WDATA(z_mem_wdata), .MEM_ACK(z_mem_ack), .MEM_RDDATA(z_mem_rddata),
    .DBG_STATE(z_dbg_state), .DBG_STREAK(z_dbg_streak)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    logic        rst, i_req, d_rden, d_wren, mem_ack;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        e_req, e_we, e_iack, e_dack, e_stall;
    logic [3:0]  e_strb;
    logic [31:0] e_addr, e_drd, e_ird;
  } vec_t;

  vec_t vq[$];
  vec_t v;

  function automatic void add(string nm, int rs, int ir, int dr, int dw,
                              logic [3:0] st, int ma, logic [31:0] rd,
                              int er, int ew, logic [3:0] es, logic [31:0] ea,
                              int eia, int eda, int est,
                              logic [31:0] edr, logic [31:0] eir);
    vec_t t;
    t.name = nm;  t.rst = (rs != 0); t.i_req = (ir != 0);
    t.d_rden = (dr != 0); t.d_wren = (dw != 0); t.strb = st;
    t.mem_ack = (ma != 0); t.rdata = rd;
    t.e_req = (er != 0); t.e_we = (ew != 0); t.e_strb = es; t.e_addr = ea;
    t.e_iack = (eia != 0); t.e_dack = (eda != 0); t.e_stall = (est != 0);
    t.e_drd = edr; t.e_ird = eir;
    vq.push_back(t);
  endfunction

  // ---------------- reference model state ----------------
  int          m_owner;   // 0 bus free, 1 fetch owns it, 2 load/store owns it
  bit          m_cool;
  int          m_streak;
  logic        m_we;
  logic [3:0]  m_strb;
  logic [31:0] m_addr, m_wdata, m_ird, m_drd;
  logic        e_iack, e_dack;
  int          n_igr, n_dgr;

  task automatic model_step();
    logic d;
    d = d_rden | d_wren;
    e_iack = 1'b0;
    e_dack = 1'b0;
    if (m_owner != 0) begin
      if (mem_ack) begin
        if (m_owner == 1) begin
          e_iack = 1'b1;
          m_ird  = mem_rddata;
        end else begin
          e_dack = 1'b1;
          if (!m_we) m_drd = mem_rddata;
        end
        m_owner = 0;
        m_cool  = 1'b1;
      end
    end else if (m_cool) begin
      m_cool = 1'b0;
    end else if (d && (!i_req || LIM == 0 || m_streak < LIM)) begin
      m_owner  = 2;
      m_we     = d_wren;
      m_addr   = d_addr;
      m_strb   = d_wren ? d_strb : 4'hF;
      m_wdata  = d_wrdata;
      m_streak = i_req ? ((m_streak < LIM) ? m_streak + 1 : LIM) : 0;
      n_dgr++;
    end else if (i_req) begin
      m_owner  = 1;
      m_we     = 1'b0;
      m_addr   = i_addr;
      m_strb   = 4'hF;
      m_streak = 0;
      n_igr++;
    end else begin
      m_streak = 0;
    end
  endtask

  logic exp_is_i[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  int   exp_st[6]   = '{1, 2, 3, 4, 0, 1};

  initial begin
    int   g, nd, kind;
    logic prev;

    rst = 1'b1; i_req = 1'b0; d_rden = 1'b0; d_wren = 1'b0; mem_ack = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wrdata = 32'h0; d_strb = 4'h0; mem_rddata = 32'h0;
    z_i_req = 1'b0; z_d_rden = 1'b0; z_mem_ack = 1'b0; z_mem_rddata = 32'h0;
    tick();
    tick();
    check_b("rst_z_mem_req", z_mem_req, 1'b0);
    check_b("rst_z_iack", z_i_ack, 1'b0);

    //   name          rs ir dr dw strb  ma rdata         er ew estrb eaddr         ia da st drd           ird
    add("reset",       1, 0, 0, 0, 4'h0, 0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 0, 0, 32'h0,        32'h0);
    add("ld_grant",    0, 0, 1, 0, 4'h0, 0, 32'h0,        1, 0, 4'hF, 32'h100,      0, 0, 1, 32'h0,        32'h0);
    add("ld_ack",      0, 0, 1, 0, 4'h0, 1, 32'hDEADBEEF, 0, 0, 4'h0, 32'h0,        0, 1, 0, 32'hDEADBEEF, 32'h0);
    add("ld_idle",     0, 0, 0, 0, 4'h0, 0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 0, 0, 32'hDEADBEEF, 32'h0);
    add("st_grant",    0, 0, 0, 1, 4'h3, 0, 32'h0,        1, 1, 4'h3, 32'h100,      0, 0, 1, 32'hDEADBEEF, 32'h0);
    add("st_wait1",    0, 0, 0, 1, 4'h3, 0, 32'h0,        1, 1, 4'h3, 32'h100,      0, 0, 1, 32'hDEADBEEF, 32'h0);
    add("st_wait2",    0, 0, 0, 1, 4'h3, 0, 32'h0,        1, 1, 4'h3, 32'h100,      0, 0, 1, 32'hDEADBEEF, 32'h0);
    add("st_ack",      0, 0, 0, 1, 4'h3, 1, 32'hCAFEF00D, 0, 0, 4'h0, 32'h0,        0, 1, 0, 32'hDEADBEEF, 32'h0);
    add("st_idle",     0, 0, 0, 0, 4'h0, 0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 0, 0, 32'hDEADBEEF, 32'h0);
    add("both_dgrant", 0, 1, 1, 0, 4'h0, 0, 32'h0,        1, 0, 4'hF, 32'h100,      0, 0, 1, 32'hDEADBEEF, 32'h0);
    add("both_dack",   0, 1, 1, 0, 4'h0, 1, 32'h11111111, 0, 0, 4'h0, 32'h0,        0, 1, 0, 32'h11111111, 32'h0);
    add("both_done",   0, 1, 0, 0, 4'h0, 0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 0, 0, 32'h11111111, 32'h0);
    add("i_grant",     0, 1, 0, 0, 4'h0, 0, 32'h0,        1, 0, 4'hF, 32'h2000,     0, 0, 0, 32'h11111111, 32'h0);
    add("i_ack",       0, 1, 0, 0, 4'h0, 1, 32'h22222222, 0, 0, 4'h0, 32'h0,        1, 0, 0, 32'h11111111, 32'h22222222);
    add("i_idle",      0, 0, 0, 0, 4'h0, 0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 0, 0, 32'h11111111, 32'h22222222);
    add("stray_ack",   0, 0, 0, 0, 4'h0, 1, 32'h99999999, 0, 0, 4'h0, 32'h0,        0, 0, 0, 32'h11111111, 32'h22222222);
    add("stray_after", 0, 0, 0, 0, 4'h0, 0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 0, 0, 32'h11111111, 32'h22222222);

    i_addr = 32'h2000; d_addr = 32'h100; d_wrdata = 32'h1234;
    for (int k = 0; k < vq.size(); k++) begin
      v = vq[k];
      rst = v.rst; i_req = v.i_req; d_rden = v.d_rden; d_wren = v.d_wren;
      d_strb = v.strb; mem_ack = v.mem_ack; mem_rddata = v.rdata;
      tick();
      check_b({v.name, "_mem_req"}, mem_req, v.e_req);
      if (v.e_req || v.rst) begin
        check_b({v.name, "_mem_we"}, mem_we, v.e_we);
        check32({v.name, "_mem_addr"}, mem_addr, v.e_addr);
        check32({v.name, "_mem_strb"}, 32'(mem_strb), 32'(v.e_strb));
      end
      if (v.e_req && v.e_we) check32({v.name, "_mem_wdata"}, mem_wdata, 32'h1234);
      if (v.rst) check32({v.name, "_mem_wdata"}, mem_wdata, 32'h0);
      check_b({v.name, "_i_ack"}, i_ack, v.e_iack);
      check_b({v.name, "_d_ack"}, d_ack, v.e_dack);
      check_b({v.name, "_stall"}, stall, v.e_stall);
      check32({v.name, "_d_rddata"}, d_rddata, v.e_drd);
      check32({v.name, "_i_rddata"}, i_rddata, v.e_ird);
    end
    rst = 1'b0; mem_ack = 1'b0;

    // Starvation limit: fetch waits behind exactly LIM back-to-back loads.
    i_req = 1'b1; i_addr = 32'h2000; d_rden = 1'b1; d_wren = 1'b0; d_addr = 32'h100;
    g = 0;
    prev = mem_req;
    for (int c = 0; c < 60 && g < 6; c++) begin
      mem_ack = mem_req;
      mem_rddata = $urandom();
      tick();
      if (mem_req && !prev) begin
        check_b($sformatf("t4_owner_is_i_%0d", g), mem_addr == 32'h2000, exp_is_i[g]);
        check32($sformatf("t4_streak_%0d", g), 32'(dbg_streak), 32'(exp_st[g]));
        g++;
      end
      prev = mem_req;
    end
    check32("t4_grant_count", 32'(g), 32'd6);
    i_req = 1'b0; d_rden = 1'b0;
    for (int c = 0; c < 5; c++) begin
      mem_ack = mem_req;
      tick();
    end
    mem_ack = 1'b0;

    // Reset in the middle of a granted load; the late MEM_ACK must be ignored.
    d_rden = 1'b1; d_addr = 32'h100;
    tick();
    check_b("t5_grant", mem_req, 1'b1);
    rst = 1'b1;
    tick();
    check_b("t5_rst_mem_req", mem_req, 1'b0);
    check_b("t5_rst_mem_we", mem_we, 1'b0);
    check32("t5_rst_mem_addr", mem_addr, 32'h0);
    check32("t5_rst_mem_strb", 32'(mem_strb), 32'h0);
    check32("t5_rst_mem_wdata", mem_wdata, 32'h0);
    check_b("t5_rst_d_ack", d_ack, 1'b0);
    check_b("t5_rst_i_ack", i_ack, 1'b0);
    check32("t5_rst_d_rddata", d_rddata, 32'h0);
    check32("t5_rst_i_rddata", i_rddata, 32'h0);
    check_b("t5_rst_stall", stall, 1'b1);
    check32("t5_rst_state", 32'(dbg_state), 32'h0);
    check32("t5_rst_streak", 32'(dbg_streak), 32'h0);
    rst = 1'b0; d_rden = 1'b0;
    tick();
    check_b("t5_idle_mem_req", mem_req, 1'b0);
    mem_ack = 1'b1; mem_rddata = 32'hBAD0BAD0;
    tick();
    check_b("t5_late_ack_d_ack", d_ack, 1'b0);
    check32("t5_late_ack_d_rddata", d_rddata, 32'h0);
    check_b("t5_late_ack_mem_req", mem_req, 1'b0);
    mem_ack = 1'b0;
    tick();
    check_b("t5_after_d_ack", d_ack, 1'b0);

    // Randomized traffic against the reference model.
    m_owner = 0; m_cool = 1'b0; m_streak = 0; m_ird = 32'h0; m_drd = 32'h0;
    m_we = 1'b0; m_strb = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
    n_igr = 0; n_dgr = 0;
    for (int c = 0; c < 2000; c++) begin
      if (i_ack) begin
        i_req = 1'b0;
      end else if (!i_req && $urandom_range(0, 3) == 0) begin
        i_req  = 1'b1;
        i_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (d_ack) begin
        d_rden = 1'b0;
        d_wren = 1'b0;
      end else if (!d_rden && !d_wren && $urandom_range(0, 2) == 0) begin
        kind     = int'($urandom_range(0, 4));
        d_rden   = (kind < 2) || (kind == 4);
        d_wren   = (kind >= 2);
        d_addr   = $urandom() & 32'hFFFF_FFFC;
        d_strb   = 4'($urandom_range(1, 15));
        d_wrdata = $urandom();
      end
      mem_ack    = mem_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      mem_rddata = $urandom();
      model_step();
      tick();
      check_b("r_mem_req", mem_req, m_owner != 0);
      if (m_owner != 0) begin
        check_b("r_mem_we", mem_we, m_we);
        check32("r_mem_addr", mem_addr, m_addr);
        check32("r_mem_strb", 32'(mem_strb), 32'(m_strb));
        if (m_we) check32("r_mem_wdata", mem_wdata, m_wdata);
      end
      check_b("r_i_ack", i_ack, e_iack);
      check_b("r_d_ack", d_ack, e_dack);
      check32("r_i_rddata", i_rddata, m_ird);
      check32("r_d_rddata", d_rddata, m_drd);
      check_b("r_stall", stall, (d_rden | d_wren) & ~e_dack);
      check32("r_streak", 32'(dbg_streak), 32'(m_streak));
    end
    check_b("r_saw_i_grants", n_igr > 0, 1'b1);
    check_b("r_saw_d_grants", n_dgr > 0, 1'b1);
    i_req = 1'b0; d_rden = 1'b0; d_wren = 1'b0; mem_ack = 1'b0;

    // Strict D priority: fetch is never granted while loads keep coming.
    z_i_req = 1'b1; z_d_rden = 1'b1;
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      z_mem_ack    = z_mem_req;
      z_mem_rddata = $urandom();
      tick();
      check_b("t6_no_i_ack", z_i_ack, 1'b0);
      if (z_mem_req) check32("t6_mem_addr", z_mem_addr, 32'h0000_0400);
      if (z_d_ack) nd++;
    end
    check32("t6_d_ack_count", 32'(nd), 32'd10);
    z_i_req = 1'b0; z_d_rden = 1'b0; z_mem_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
